ring_dir_mem_ctrl: RTL and testbench

- Synthesizable successor to the simulation-only ring memory controller; sits at ring position 0, tapping the ring output of the last core.
- Captures `Address`/`WriteData` slots; keeps a 2-bit-per-line coherence directory (CLEAN/WAITING/MODIFIED).
- Moves LINE_WORDS-word lines to and from an external single-port memory.
- Returns read data on the RDreturn/RDdest bus; pushes grants and retries into the ring controller's resend queue.
- New over the previous generation: parametrised line, address, FIFO depths and memory latency; resend-queue backpressure; write-data underflow protection; on-chip directory initialisation sweep; error counters.

---
 rtl/ring_dir_mem_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_ring_dir_mem_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_dir_mem_ctrl.sv
// Ring memory controller with per-line coherence directory.
//
// Sits at ring position 0 and snoops the last core's output slot. Address slots
// are queued in the MA FIFO, write-data slots in the MD FIFO. The head request is
// checked against a 2-bit directory (clean / waiting / modified). It is then
// served from the external single-port memory, granted, or bounced back through
// the ring's resend queue.
//
// Ports
//   clock, reset            system clock, asynchronous active-high reset
//   SlotTypeIn/SourceIn/RingIn  slot observed from the last core
//   RDreturn, RDdest        read-data bus and destination core (0 = idle)
//   rq_wr, rq_din, rq_full  resend-queue push {dest, type, payload} with backpressure
//   mem_*                   external memory, read data RD_LAT cycles after mem_re
//   init_done               directory initialisation sweep finished
//   bad_addr_cnt            saturating count of out-of-range requests
//   ovf_err                 sticky: a slot was dropped on a full FIFO
module ring_dir_mem_ctrl #(
    parameter int unsigned MBITS           = 24,
    parameter int unsigned LOG_LINE        = 3,
    parameter int unsigned MA_LOG          = 9,
    parameter int unsigned MD_LOG          = 12,
    parameter int unsigned RD_LAT          = 1,
    parameter int unsigned PRE_MOD         = 128,
    parameter logic [3:0]  SLOT_ADDRESS    = 4'h1,
    parameter logic [3:0]  SLOT_WRITE_DATA = 4'h2,
    parameter logic [3:0]  SLOT_GRANT_EXCL = 4'h3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       SlotTypeIn,
    input  logic [3:0]       SourceIn,
    input  logic [31:0]      RingIn,
    output logic [31:0]      RDreturn,
    output logic [3:0]       RDdest,
    output logic             rq_wr,
    output logic [39:0]      rq_din,
    input  logic             rq_full,
    output logic [MBITS-1:0] mem_addr,
    output logic             mem_re,
    output logic             mem_we,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             init_done,
    output logic [15:0]      bad_addr_cnt,
    output logic             ovf_err
);
    localparam int unsigned LINE_BITS = MBITS - LOG_LINE;
    localparam int unsigned NLINES    = 1 << LINE_BITS;
    localparam int unsigned LINE_WORDS = 1 << LOG_LINE;
    localparam int unsigned MA_DEPTH  = 1 << MA_LOG;
    localparam int unsigned MD_DEPTH  = 1 << MD_LOG;

    typedef enum logic [1:0] {DirClean = 2'd0, DirWaiting = 2'd1, DirModified = 2'd2} dir_t;
    typedef enum logic [2:0] {StInit, StIdle, StRead, StDrain, StWrite} state_t;

    // ---------------- MA FIFO: {source, address word} ----------------
    logic [35:0]     ma_mem [MA_DEPTH];
    logic [MA_LOG-1:0] ma_wp_q, ma_rp_q;
    logic [MA_LOG:0] ma_cnt_q;
    logic            ma_push, ma_full, ma_push_ok, ma_pop, ma_empty;
    logic [35:0]     ma_head;

    assign ma_push    = (SlotTypeIn == SLOT_ADDRESS);
    assign ma_full    = (ma_cnt_q == (MA_LOG + 1)'(MA_DEPTH));
    assign ma_empty   = (ma_cnt_q == '0);
    assign ma_push_ok = ma_push & ~ma_full;
    assign ma_head    = ma_mem[ma_rp_q];

    always_ff @(posedge clock) begin
        if (ma_push_ok) ma_mem[ma_wp_q] <= {SourceIn, RingIn};
    end

    // ---------------- MD FIFO: write data words ----------------
    logic [31:0]     md_mem [MD_DEPTH];
    logic [MD_LOG-1:0] md_wp_q, md_rp_q;
    logic [MD_LOG:0] md_cnt_q;
    logic            md_push, md_full, md_push_ok, md_pop;
    logic [31:0]     md_head;

    assign md_push    = (SlotTypeIn == SLOT_WRITE_DATA);
    assign md_full    = (md_cnt_q == (MD_LOG + 1)'(MD_DEPTH));
    assign md_push_ok = md_push & ~md_full;
    assign md_head    = md_mem[md_rp_q];

    always_ff @(posedge clock) begin
        if (md_push_ok) md_mem[md_wp_q] <= RingIn;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ma_wp_q  <= '0;
            ma_rp_q  <= '0;
            ma_cnt_q <= '0;
            md_wp_q  <= '0;
            md_rp_q  <= '0;
            md_cnt_q <= '0;
            ovf_err  <= 1'b0;
        end else begin
            if (ma_push_ok) ma_wp_q <= ma_wp_q + 1'b1;
            if (ma_pop)     ma_rp_q <= ma_rp_q + 1'b1;
            ma_cnt_q <= ma_cnt_q + (MA_LOG + 1)'(ma_push_ok) - (MA_LOG + 1)'(ma_pop);
            if (md_push_ok) md_wp_q <= md_wp_q + 1'b1;
            if (md_pop)     md_rp_q <= md_rp_q + 1'b1;
            md_cnt_q <= md_cnt_q + (MD_LOG + 1)'(md_push_ok) - (MD_LOG + 1)'(md_pop);
            if ((ma_push & ma_full) | (md_push & md_full)) ovf_err <= 1'b1;
        end
    end

    // ---------------- Head request decode ----------------
    logic [3:0]           h_dest;
    logic [31:0]          h_addr;
    logic                 h_retry, h_grant, h_mod, h_read, h_in_range, read_possible;
    logic [LINE_BITS-1:0] h_line;
    dir_t                 dir_q [NLINES];
    dir_t                 h_dir;

    assign h_dest     = ma_head[35:32];
    assign h_addr     = ma_head[31:0];
    assign h_retry    = h_addr[31];
    assign h_grant    = h_addr[30];
    assign h_mod      = h_addr[29];
    assign h_read     = h_addr[28];
    assign h_in_range = ((h_addr[27:0] >> LINE_BITS) == 28'd0);
    assign h_line     = h_addr[LINE_BITS-1:0];
    assign h_dir      = dir_q[h_line];
    assign read_possible = (h_dir == DirClean) | ((h_dir == DirWaiting) & h_retry);

    // ---------------- Decision logic ----------------
    state_t               state_q, state_d;
    logic [LINE_BITS-1:0] init_idx_q;
    logic [LOG_LINE-1:0]  cnt_q;
    logic                 cnt_last;
    logic                 dir_we, rq_send, bad_inc;
    logic [LINE_BITS-1:0] dir_idx;
    dir_t                 dir_wval;
    logic [39:0]          rq_val;
    logic [RD_LAT:0]      pipe_vld_q;
    logic [3:0]           pipe_dest_q [RD_LAT+1];

    assign cnt_last = (cnt_q == {LOG_LINE{1'b1}});

    always_comb begin
        state_d  = state_q;
        ma_pop   = 1'b0;
        md_pop   = 1'b0;
        dir_we   = 1'b0;
        dir_idx  = h_line;
        dir_wval = DirClean;
        rq_send  = 1'b0;
        rq_val   = '0;
        bad_inc  = 1'b0;
        unique case (state_q)
            StInit: begin
                dir_we   = 1'b1;
                dir_idx  = init_idx_q;
                dir_wval = (32'(init_idx_q) < PRE_MOD) ? DirModified : DirClean;
                if (init_idx_q == LINE_BITS'(NLINES - 1)) state_d = StIdle;
            end
            StIdle: begin
                if (!ma_empty) begin
                    if (!h_in_range) begin
                        ma_pop  = 1'b1;
                        bad_inc = 1'b1;
                    end else if (h_read) begin
                        if (!read_possible) begin
                            // Bounce the request back marked as a retry.
                            if (!rq_full) begin
                                rq_send = 1'b1;
                                rq_val  = {h_dest, SLOT_ADDRESS, 2'b10, h_addr[29:0]};
                                ma_pop  = 1'b1;
                            end
                        end else if (h_grant) begin
                            if (!rq_full) begin
                                rq_send  = 1'b1;
                                rq_val   = {h_dest, SLOT_GRANT_EXCL, 4'b0, h_addr[27:0]};
                                dir_we   = 1'b1;
                                dir_wval = h_mod ? DirModified : DirClean;
                                ma_pop   = 1'b1;
                            end
                        end else begin
                            state_d = StRead;
                        end
                    end else if (32'(md_cnt_q) >= LINE_WORDS) begin
                        // Only start once a whole line of data is buffered.
                        state_d = StWrite;
                    end
                end
            end
            StRead: begin
                if (cnt_last) begin
                    // Directory update rides with the MA pop so the request is
                    // retired atomically.
                    dir_we   = 1'b1;
                    dir_wval = h_mod ? DirModified : DirClean;
                    ma_pop   = 1'b1;
                    state_d  = StDrain;
                end
            end
            StDrain: begin
                if (pipe_vld_q == '0) state_d = StIdle;
            end
            StWrite: begin
                md_pop = 1'b1;
                if (cnt_last) begin
                    dir_we   = 1'b1;
                    dir_wval = h_mod ? DirWaiting : DirClean;
                    ma_pop   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Directory has no reset; the INIT sweep defines every entry.
    always_ff @(posedge clock) begin
        if (dir_we) dir_q[dir_idx] <= dir_wval;
    end

    // ---------------- FSM and registered outputs ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StInit;
            init_idx_q   <= '0;
            init_done    <= 1'b0;
            cnt_q        <= '0;
            bad_addr_cnt <= '0;
            rq_wr        <= 1'b0;
            rq_din       <= '0;
            mem_re       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            state_q <= state_d;
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            rq_wr   <= rq_send;
            if (rq_send) rq_din <= rq_val;
            if (bad_inc && bad_addr_cnt != 16'hFFFF) bad_addr_cnt <= bad_addr_cnt + 16'd1;
            if (state_q == StInit) begin
                init_idx_q <= init_idx_q + 1'b1;
                if (state_d == StIdle) init_done <= 1'b1;
            end
            if (state_q == StRead) begin
                mem_re   <= 1'b1;
                mem_addr <= {h_line, cnt_q};
                cnt_q    <= cnt_q + 1'b1;
            end
            if (state_q == StWrite) begin
                mem_we    <= 1'b1;
                mem_addr  <= {h_line, cnt_q};
                mem_wdata <= md_head;
                cnt_q     <= cnt_q + 1'b1;
            end
        end
    end

    // ---------------- Read-return tracking ----------------
    // Stage 0 coincides with the mem_re cycle; stage RD_LAT with valid mem_rdata.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_vld_q <= '0;
            for (int unsigned i = 0; i <= RD_LAT; i++) pipe_dest_q[i] <= '0;
        end else begin
            pipe_vld_q     <= {pipe_vld_q[RD_LAT-1:0], (state_q == StRead)};
            pipe_dest_q[0] <= h_dest;
            for (int unsigned i = 1; i <= RD_LAT; i++) pipe_dest_q[i] <= pipe_dest_q[i-1];
        end
    end

    assign RDreturn = pipe_vld_q[RD_LAT] ? mem_rdata : 32'd0;
    assign RDdest   = pipe_vld_q[RD_LAT] ? pipe_dest_q[RD_LAT] : 4'd0;

endmodule

// File: tb/tb_ring_dir_mem_ctrl.sv
module tb_ring_dir_mem_ctrl;
    localparam logic [3:0] T_IDLE = 4'h0;
    localparam logic [3:0] T_ADDR = 4'h1;
    localparam logic [3:0] T_WDAT = 4'h2;
    localparam logic [3:0] T_GRNT = 4'h3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  SlotTypeIn = T_IDLE;
    logic [3:0]  SourceIn = 4'd0;
    logic [31:0] RingIn = 32'd0;
    logic [31:0] RDreturn;
    logic [3:0]  RDdest;
    logic        rq_wr;
    logic [39:0] rq_din;
    logic        rq_full = 1'b0;
    logic [7:0]  mem_addr;
    logic        mem_re, mem_we;
    logic [31:0] mem_wdata, mem_rdata;
    logic        init_done;
    logic [15:0] bad_addr_cnt;
    logic        ovf_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    ring_dir_mem_ctrl #(
        .MBITS(8), .LOG_LINE(3), .MA_LOG(3), .MD_LOG(4), .RD_LAT(2), .PRE_MOD(8),
        .SLOT_ADDRESS(T_ADDR), .SLOT_WRITE_DATA(T_WDAT), .SLOT_GRANT_EXCL(T_GRNT)
    ) dut (
        .clock(clock), .reset(reset),
        .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn), .RingIn(RingIn),
        .RDreturn(RDreturn), .RDdest(RDdest),
        .rq_wr(rq_wr), .rq_din(rq_din), .rq_full(rq_full),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .init_done(init_done), .bad_addr_cnt(bad_addr_cnt), .ovf_err(ovf_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Memory model: two-cycle read latency, writes land on the clock edge.
    logic [31:0] mem_model [256];
    logic [7:0]  lat_addr0 = 8'd0;
    logic [7:0]  lat_addr1 = 8'd0;
    always @(posedge clock) begin
        lat_addr0 <= mem_addr;
        lat_addr1 <= lat_addr0;
        if (mem_we) mem_model[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem_model[lat_addr1];

    function automatic logic [31:0] seed(input int a);
        return 32'hD000_0000 + 32'(a) * 32'd7;
    endfunction

    function automatic logic [31:0] aw(input bit rt, input bit gr, input bit md, input bit rd,
                                       input logic [27:0] ln);
        return {rt, gr, md, rd, ln};
    endfunction

    // Event logs, sampled on the falling edge.
    logic [7:0]  re_addr [$];
    int          re_cyc  [$];
    logic [31:0] ret_data [$];
    logic [3:0]  ret_dest [$];
    int          ret_cyc  [$];
    logic [7:0]  we_addr [$];
    logic [31:0] we_data [$];
    logic [39:0] rq_log  [$];

    always @(negedge clock) begin
        if (mem_re) begin re_addr.push_back(mem_addr); re_cyc.push_back(cyc); end
        if (RDdest != 4'd0) begin
            ret_data.push_back(RDreturn); ret_dest.push_back(RDdest); ret_cyc.push_back(cyc);
        end
        if (mem_we) begin we_addr.push_back(mem_addr); we_data.push_back(mem_wdata); end
        if (rq_wr) rq_log.push_back(rq_din);
    end

    task automatic clear_logs();
        re_addr.delete(); re_cyc.delete(); ret_data.delete(); ret_dest.delete();
        ret_cyc.delete(); we_addr.delete(); we_data.delete(); rq_log.delete();
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic slot(input logic [3:0] t, input logic [3:0] s, input logic [31:0] p);
        @(negedge clock);
        SlotTypeIn = t; SourceIn = s; RingIn = p;
        @(negedge clock);
        SlotTypeIn = T_IDLE; SourceIn = 4'd0; RingIn = 32'd0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_init(input string tag);
        int i;
        for (i = 1; i <= 100; i++) begin
            @(posedge clock); #1;
            if (init_done) break;
        end
        check(tag, 64'(i), 64'd32);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem_model[a] = seed(a);

        // ---- reset state ----
        run(2);
        check("rst_rdest", 64'(RDdest), 64'd0);
        check("rst_rq_wr", 64'(rq_wr), 64'd0);
        check("rst_mem_re_we", 64'({mem_re, mem_we}), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_bad_cnt", 64'(bad_addr_cnt), 64'd0);
        check("rst_ovf", 64'(ovf_err), 64'd0);

        // ---- directory sweep ----
        reset = 1'b0;
        wait_init("init_cycles");
        @(negedge clock);
        check("dir0_mod", 64'(dut.dir_q[0]), 64'd2);
        check("dir7_mod", 64'(dut.dir_q[7]), 64'd2);
        check("dir8_clean", 64'(dut.dir_q[8]), 64'd0);
        check("dir31_clean", 64'(dut.dir_q[31]), 64'd0);

        // ---- read of a clean line ----
        clear_logs();
        slot(T_ADDR, 4'd3, aw(0, 0, 0, 1, 28'd20));
        run(30);
        check("rd_re_count", 64'(re_addr.size()), 64'd8);
        check("rd_ret_count", 64'(ret_data.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check("rd_addr", 64'(re_addr[i]), 64'(160 + i));
            check("rd_consec", 64'(re_cyc[i]), 64'(re_cyc[0] + i));
            check("rd_data", 64'(ret_data[i]), 64'(seed(160 + i)));
            check("rd_dest", 64'(ret_dest[i]), 64'd3);
            check("rd_latency", 64'(ret_cyc[i]), 64'(re_cyc[i] + 2));
        end
        check("rd_no_rq", 64'(rq_log.size()), 64'd0);
        check("rd_dir_clean", 64'(dut.dir_q[20]), 64'd0);

        // ---- read of a modified line bounces ----
        clear_logs();
        slot(T_ADDR, 4'd2, aw(0, 0, 0, 1, 28'd5));
        run(10);
        check("mod_rq_count", 64'(rq_log.size()), 64'd1);
        check("mod_rq_din", 64'(rq_log[0]), 64'h02_1_9000_0005);
        check("mod_no_re", 64'(re_addr.size()), 64'd0);

        // ---- write waits for a full line ----
        clear_logs();
        slot(T_ADDR, 4'd6, aw(0, 0, 1, 0, 28'd9));
        for (int i = 0; i < 5; i++) slot(T_WDAT, 4'd6, 32'hC0DE_0000 + 32'(i));
        run(10);
        check("wr_partial_no_we", 64'(we_addr.size()), 64'd0);
        for (int i = 5; i < 8; i++) slot(T_WDAT, 4'd6, 32'hC0DE_0000 + 32'(i));
        run(20);
        check("wr_we_count", 64'(we_addr.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check("wr_addr", 64'(we_addr[i]), 64'(72 + i));
            check("wr_data", 64'(we_data[i]), 64'(32'hC0DE_0000 + 32'(i)));
        end
        check("wr_dir_waiting", 64'(dut.dir_q[9]), 64'd1);

        // ---- waiting line: plain read bounces, retry is served ----
        clear_logs();
        slot(T_ADDR, 4'd6, aw(0, 0, 0, 1, 28'd9));
        run(10);
        check("wait_rq_count", 64'(rq_log.size()), 64'd1);
        check("wait_rq_din", 64'(rq_log[0]), 64'h06_1_9000_0009);
        check("wait_no_re", 64'(re_addr.size()), 64'd0);
        clear_logs();
        slot(T_ADDR, 4'd6, aw(1, 0, 0, 1, 28'd9));
        run(30);
        check("retry_ret_count", 64'(ret_data.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check("retry_data", 64'(ret_data[i]), 64'(32'hC0DE_0000 + 32'(i)));
            check("retry_dest", 64'(ret_dest[i]), 64'd6);
        end
        check("retry_dir_clean", 64'(dut.dir_q[9]), 64'd0);

        // ---- grant-only under resend-queue backpressure ----
        clear_logs();
        rq_full = 1'b1;
        slot(T_ADDR, 4'd4, aw(0, 1, 1, 1, 28'd22));
        run(10);
        check("gnt_hold_no_rq", 64'(rq_log.size()), 64'd0);
        check("gnt_hold_dir", 64'(dut.dir_q[22]), 64'd0);
        rq_full = 1'b0;
        run(5);
        check("gnt_rq_count", 64'(rq_log.size()), 64'd1);
        check("gnt_rq_din", 64'(rq_log[0]), 64'h04_3_0000_0016);
        check("gnt_dir_mod", 64'(dut.dir_q[22]), 64'd2);
        check("gnt_no_re", 64'(re_addr.size()), 64'd0);

        // ---- out-of-range line ----
        clear_logs();
        slot(T_ADDR, 4'd1, aw(0, 0, 0, 0, 28'hFFF_FFFF));
        run(10);
        check("oor_bad_cnt", 64'(bad_addr_cnt), 64'd1);
        check("oor_quiet", 64'(re_addr.size() + we_addr.size() + rq_log.size()), 64'd0);

        // ---- reset during a read ----
        slot(T_ADDR, 4'd5, aw(0, 0, 0, 1, 28'd25));
        begin
            int k;
            for (k = 0; k < 40; k++) begin
                @(negedge clock);
                if (RDdest != 4'd0) break;
            end
            check("midrd_returning", 64'(RDdest), 64'd5);
        end
        reset = 1'b1;
        #1;
        check("midrd_rdest", 64'(RDdest), 64'd0);
        check("midrd_rdreturn", 64'(RDreturn), 64'd0);
        check("midrd_mem_re", 64'(mem_re), 64'd0);
        check("midrd_mem_addr", 64'(mem_addr), 64'd0);
        check("midrd_init_done", 64'(init_done), 64'd0);
        check("midrd_bad_cnt", 64'(bad_addr_cnt), 64'd0);
        run(2);
        reset = 1'b0;
        wait_init("reinit_cycles");

        // ---- write-data FIFO overflow (depth 16) ----
        for (int i = 0; i < 16; i++) slot(T_WDAT, 4'd1, 32'(i));
        check("ovf_not_yet", 64'(ovf_err), 64'd0);
        slot(T_WDAT, 4'd1, 32'd99);
        check("ovf_set", 64'(ovf_err), 64'd1);
        run(3);
        check("ovf_sticky", 64'(ovf_err), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
